difftest_batch_packer: RTL
==========================

// Module: difftest_batch_packer
// PURPOSE
//  Write side of the difftest batch path. Packs variable-length difftest items
//  into one BATCH_W-bit byte buffer. Drives the batch sink (DPI consumer) with a
//  one-cycle enable pulse plus the packed vector. Sits between the per-event
//  difftest producers and the batch DPI sink, one instance per core.
// PARAMETERS
//  BATCH_W     16000  batch vector width, bits; BATCH_B = BATCH_W/8 = 2000 bytes
//  ITEM_BYTES  64     max payload bytes per item
//  TIMEOUT     1024   idle cycles before auto-flush (used only with the macro)
// PORTS
//  clock        in   1                  sole clock, rising edge
//  reset_n      in   1                  async assert, active-low
//  in_valid     in   1                  item offered
//  in_ready     out  1                  item accepted when in_valid && in_ready
//  in_id        in   8                  item type; 0x00 reserved (terminator)
//  in_len       in   8                  payload bytes, legal 1..ITEM_BYTES
//  in_data      in   ITEM_BYTES*8       payload; byte j = in_data[8j+7:8j]
//  flush        in   1                  close current batch (step boundary)
//  batch_enable out  1                  one-cycle strobe to the sink
//  batch_io     out  BATCH_W            packed batch; byte k = batch_io[8k+7:8k]
//  batch_count  out  32                 batches emitted, wraps at 2^32
//  err_drop     out  1                  sticky: illegal item dropped
// BEHAVIOUR
//  Reset (async, reset_n=0): state FILL, offset=0, buffer all-zero, batch_enable=0,
//   batch_io=0, batch_count=0, err_drop=0. A reset during EMIT drops
//   batch_enable immediately and discards the batch; no partial pulse.
//  Item layout at byte offset o: [o]=in_id, [o+1]=in_len, [o+2..o+1+in_len]=payload.
//   Size S=2+in_len bytes. Next item starts at o+S; no padding between items.
//  Terminator: bytes after the last item stay zero (buffer cleared on EMIT exit).
//   2 bytes are always reserved, so usable capacity is BATCH_B-2 bytes.
//  Fit rule: fits = (offset + S <= BATCH_B-2), offset held in 11-bit unsigned.
//  FSM FILL:
//   - in_ready = fits || !in_valid. in_ready may depend on in_valid/in_len;
//     producers must not make in_valid depend on in_ready.
//   - Accept: write item bytes and set offset += S next edge.
//   - Illegal item (in_len==0, in_len>ITEM_BYTES or in_id==0): in_ready=1,
//     item consumed but not written, err_drop set. Never triggers EMIT.
//   - Legal in_valid && !fits: no accept; go to EMIT. Item is retried after.
//   - flush && offset!=0 -> EMIT. Accept and flush in the same cycle: the item
//     is written first and is included in the emitted batch.
//   - flush with offset==0 and no accept: ignored, no pulse.
//  FSM EMIT (exactly 1 cycle):
//   - in_ready=0, batch_enable=1, batch_io = buffer. batch_io is a registered
//     copy, stable the whole cycle.
//   - Next edge: buffer zeroed, offset=0, batch_count++, state FILL.
//   - batch_enable=0 and batch_io holds its last value outside EMIT.
//  Latency: flush at edge N -> batch_enable high in cycle N+1 -> in_ready high
//   in cycle N+2. The sink never back-pressures.
// CONFIGURATION
//  CONFIG_DIFFTEST_BATCH_TIMEOUT_EN defined:
//   - 16-bit idle counter, cleared on every accept and on EMIT.
//   - Counts while in FILL with offset!=0.
//   - At TIMEOUT it forces FILL->EMIT as if flush were asserted.
//  Not defined: no counter; a batch closes only on flush or overflow.
// TESTING
//  - Reset, accept id=0x05 len=4 data=0xDDCCBBAA, flush -> one pulse;
//    bytes 0..5 = 05 04 AA BB CC DD; rest zero; batch_count=1.
//  - Fill with 30 items of len=64 (1980 B), offer 31st -> in_ready=0, EMIT of
//    30 items, then 31st accepted at offset 0 in the new batch.
//  - Same-cycle accept(len=8)+flush with offset=10 -> batch holds item at
//    bytes 10..19; pulse in the next cycle; offset=0 afterwards.
//  - flush on empty buffer; item with len=0; item with len=65 -> no pulse,
//    err_drop=1, offset unchanged.
//  - reset_n low during EMIT cycle -> batch_enable falls at once;
//    batch_count=0, buffer zero.
//  - Macro on, TIMEOUT=16: one item, idle 16 cycles -> auto pulse. Macro off:
//    no pulse after 10000 cycles.

Source files
------------

// File: rtl/difftest_batch_packer.sv
// Packs variable-length difftest items into one byte buffer and emits it as a single-cycle batch.
// Optional idle auto-flush: define CONFIG_DIFFTEST_BATCH_TIMEOUT_EN.
module difftest_batch_packer #(
    parameter int BATCH_W    = 16000,
    parameter int ITEM_BYTES = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_id,
    input  logic [7:0]              in_len,
    input  logic [ITEM_BYTES*8-1:0] in_data,
    input  logic                    flush,
    output logic                    batch_enable,
    output logic [BATCH_W-1:0]      batch_io,
    output logic [31:0]             batch_count,
    output logic                    err_drop
);

    localparam int BATCH_B = BATCH_W / 8;
    localparam int ITEM_W  = (ITEM_BYTES + 2) * 8;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]              state;
    logic [10:0]             offset;
    logic [BATCH_W-1:0]      buffer;
    logic [BATCH_W-1:0]      buffer_next;
    logic [11:0]             item_size;
    logic [11:0]             end_offset;
    logic [ITEM_BYTES*8-1:0] payload;
    logic [ITEM_W-1:0]       item;
    logic                    legal;
    logic                    fits;
    logic                    accept;
    logic                    drop;
    logic                    go_emit;
    logic                    timeout_hit;

    assign batch_enable = (state == ST_EMIT);

    always_comb begin
        item_size  = 12'(in_len) + 12'd2;
        end_offset = {1'b0, offset} + item_size;
        legal      = (in_id != 8'h00) && (in_len != 8'h00) && (int'(in_len) <= ITEM_BYTES);
        fits       = (end_offset <= 12'(BATCH_B - 2));
        in_ready   = (state == ST_FILL) && (!in_valid || !legal || fits);
        accept     = (state == ST_FILL) && in_valid && legal && fits;
        drop       = (state == ST_FILL) && in_valid && !legal;
        go_emit    = (state == ST_FILL) &&
                     ((in_valid && legal && !fits) ||
                      (flush && ((offset != 11'd0) || accept)) ||
                      timeout_hit);

        // Bytes beyond in_len are masked so stale payload never lands past the item.
        payload = '0;
        for (int j = 0; j < ITEM_BYTES; j++) begin
            if (j < int'(in_len)) begin
                payload[8*j +: 8] = in_data[8*j +: 8];
            end
        end
        item = {payload, in_len, in_id};

        // Everything at and above offset is still zero, so OR-ing the shifted item appends it.
        buffer_next = buffer;
        if (accept) begin
            buffer_next = buffer | (BATCH_W'(item) << {offset, 3'b000});
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FILL;
            offset      <= '0;
            buffer      <= '0;
            batch_io    <= '0;
            batch_count <= '0;
            err_drop    <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    buffer <= buffer_next;
                    if (accept) begin
                        offset <= end_offset[10:0];
                    end
                    if (drop) begin
                        err_drop <= 1'b1;
                    end
                    if (go_emit) begin
                        batch_io <= buffer_next;
                        state    <= ST_EMIT;
                    end
                end
                default: begin
                    buffer      <= '0;
                    offset      <= '0;
                    batch_count <= batch_count + 32'd1;
                    state       <= ST_FILL;
                end
            endcase
        end
    end

`ifdef CONFIG_DIFFTEST_BATCH_TIMEOUT_EN
    logic [15:0] idle_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if ((state == ST_EMIT) || accept) begin
            idle_cnt <= '0;
        end else if ((offset != 11'd0) && (idle_cnt != 16'hFFFF)) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == ST_FILL) && (offset != 11'd0) && (idle_cnt >= 16'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
